// File: rtl/wb_req_master.sv
// Queued Wishbone request master: requests enter a small FIFO and are issued one at a time.
// Define WB_TIMEOUT_EN to add an ack watchdog that ends stalled bus cycles with rsp_err set.
module wb_req_master #(
   parameter int dw      = 32,
   parameter int AW      = 26,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                 sys_clk,
   input  logic                 RESET,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [AW-1:0]        req_addr,
   input  logic [dw-1:0]        req_dat,
   input  logic [dw/8-1:0]      req_sel,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [dw-1:0]        rsp_dat,
   output logic                 rsp_err,
   output logic                 wb_stb_o,
   output logic                 wb_cyc_o,
   output logic                 wb_we_o,
   output logic [AW-1:0]        wb_addr_o,
   output logic [dw-1:0]        wb_dat_o,
   output logic [dw/8-1:0]      wb_sel_o,
   output logic [2:0]           wb_cti_o,
   input  logic [dw-1:0]        wb_dat_i,
   input  logic                 wb_ack_i,
   output logic                 busy
);

   localparam int SW = dw / 8;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = 1 + AW + dw + SW;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RSP  = 2'd2
   } state_t;

   logic [EW-1:0] mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   state_t        state_r;
   logic          push_s;
   logic          pop_s;
   logic [EW-1:0] head_s;

`ifdef WB_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
   logic [7:0] tmo_cnt_r;
`else
   assign rsp_err = 1'b0;
`endif

   assign req_ready = (count_r < CW'(DEPTH));
   assign push_s    = req_valid && req_ready;
   assign pop_s     = (state_r == IDLE) && (count_r != {CW{1'b0}});
   assign head_s    = mem_r[rd_ptr_r];
   assign busy      = (count_r != {CW{1'b0}}) || (state_r != IDLE);
   assign wb_cti_o  = 3'b000;

   // FIFO storage; contents need no reset because count_r gates every read
   always_ff @(posedge sys_clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {req_we, req_addr, req_dat, req_sel};
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge sys_clk or posedge RESET) begin
      if (RESET) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Transaction FSM with registered bus and response outputs
   always_ff @(posedge sys_clk or posedge RESET) begin
      if (RESET) begin
         state_r   <= IDLE;
         wb_stb_o  <= 1'b0;
         wb_cyc_o  <= 1'b0;
         wb_we_o   <= 1'b0;
         wb_addr_o <= {AW{1'b0}};
         wb_dat_o  <= {dw{1'b0}};
         wb_sel_o  <= {SW{1'b0}};
         rsp_valid <= 1'b0;
         rsp_dat   <= {dw{1'b0}};
`ifdef WB_TIMEOUT_EN
         rsp_err   <= 1'b0;
         tmo_cnt_r <= 8'd0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               // also terminates the one-cycle write-timeout pulse
               rsp_valid <= 1'b0;
`ifdef WB_TIMEOUT_EN
               rsp_err   <= 1'b0;
`endif
               if (pop_s) begin
                  {wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o} <= head_s;
                  wb_stb_o <= 1'b1;
                  wb_cyc_o <= 1'b1;
`ifdef WB_TIMEOUT_EN
                  tmo_cnt_r <= 8'd0;
`endif
                  state_r  <= BUS;
               end
            end
            BUS: begin
               if (wb_ack_i) begin
                  wb_stb_o <= 1'b0;
                  wb_cyc_o <= 1'b0;
                  wb_we_o  <= 1'b0;
                  wb_sel_o <= {SW{1'b0}};
                  if (wb_we_o) begin
                     state_r <= IDLE;
                  end else begin
                     rsp_dat   <= wb_dat_i;
                     rsp_valid <= 1'b1;
`ifdef WB_TIMEOUT_EN
                     rsp_err   <= 1'b0;
`endif
                     state_r   <= RSP;
                  end
               end
`ifdef WB_TIMEOUT_EN
               else if (tmo_cnt_r == TMO_LAST) begin
                  // a timed-out write reports through a single-cycle pulse from IDLE
                  wb_stb_o  <= 1'b0;
                  wb_cyc_o  <= 1'b0;
                  wb_we_o   <= 1'b0;
                  wb_sel_o  <= {SW{1'b0}};
                  rsp_dat   <= {dw{1'b0}};
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state_r   <= wb_we_o ? IDLE : RSP;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + 8'd1;
               end
`endif
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state_r   <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
